// File: rtl/lsu_bytelane.sv
// Load/store unit for the single-cycle RV32I core.
// Handles byte/half/word accesses to data memory and to the board I/O block
// (LEDs, 7-segment digits, LCD, switches, buttons). Loads return one cycle
// after the request. Misaligned or illegal-size accesses raise a one-cycle
// error pulse and change no state.
module lsu_bytelane #(
  parameter int          DMEM_WORDS = 2048,
  parameter logic [31:0] DMEM_BASE  = 32'h0000_2000,
  parameter int          NUM_HEX    = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_lsu_req,
  input  logic                 i_lsu_wren,
  input  logic [31:0]          i_lsu_addr,
  input  logic [2:0]           i_lsu_size,
  input  logic [31:0]          i_st_data,
  input  logic [31:0]          i_io_sw,
  input  logic [3:0]           i_io_btn,
  output logic [31:0]          o_ld_data,
  output logic                 o_ld_valid,
  output logic                 o_err,
  output logic [31:0]          o_io_ledr,
  output logic [31:0]          o_io_ledg,
  output logic [7*NUM_HEX-1:0] o_io_hex,
  output logic [31:0]          o_io_lcd
);

  localparam int          AW         = $clog2(DMEM_WORDS);
  localparam int          DMEM_SHIFT = AW + 2;
  localparam logic [31:0] DMEM_TAG   = DMEM_BASE >> DMEM_SHIFT;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  // Storage
  logic [31:0] r_dmem [DMEM_WORDS];
  logic [31:0] r_ledr;
  logic [31:0] r_ledg;
  logic [31:0] r_lcd;
  // Eight digit slots are always kept so the read mux is uniform; slots at or
  // beyond NUM_HEX are never written and therefore read back as zero.
  logic [6:0]  r_hex [8];
  logic [31:0] r_sw_s1;
  logic [31:0] r_sw_s2;
  logic [3:0]  r_btn_s1;
  logic [3:0]  r_btn_s2;
  logic [31:0] r_ld_data;
  logic        r_ld_valid;
  logic        r_err;

  // Request decode
  logic [1:0]    w_off;
  logic          w_is_byte;
  logic          w_is_half;
  logic          w_is_word;
  logic          w_is_unsigned;
  logic          w_size_bad;
  logic          w_misalign;
  logic          w_err;
  logic          w_go;
  logic          w_st;
  logic          w_ld;
  logic          w_sel_dmem;
  logic          w_sel_ledr;
  logic          w_sel_ledg;
  logic          w_sel_hex;
  logic          w_sel_lcd;
  logic          w_sel_sw;
  logic          w_sel_btn;
  logic [AW-1:0] w_idx;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata;
  logic [31:0]   w_hex_word;
  logic [31:0]   w_rd_word;
  logic [31:0]   w_lane;
  logic [31:0]   w_ext;

  assign w_off = i_lsu_addr[1:0];

  // Size code decode; anything outside the five RV32I load/store widths is illegal
  always_comb begin
    w_is_byte     = 1'b0;
    w_is_half     = 1'b0;
    w_is_word     = 1'b0;
    w_is_unsigned = 1'b0;
    w_size_bad    = 1'b0;
    case (i_lsu_size)
      SZ_B:  w_is_byte = 1'b1;
      SZ_H:  w_is_half = 1'b1;
      SZ_W:  w_is_word = 1'b1;
      SZ_BU: begin
        w_is_byte     = 1'b1;
        w_is_unsigned = 1'b1;
      end
      SZ_HU: begin
        w_is_half     = 1'b1;
        w_is_unsigned = 1'b1;
      end
      default: w_size_bad = 1'b1;
    endcase
  end

  assign w_misalign = (w_is_half & w_off[0]) | (w_is_word & (w_off != 2'b00));
  assign w_err      = w_size_bad | w_misalign;
  // Reset wins over a same-cycle request, so a request during reset is dropped.
  assign w_go       = i_lsu_req & ~w_err & ~i_rst;
  assign w_st       = w_go & i_lsu_wren;
  assign w_ld       = w_go & ~i_lsu_wren;

  // DMEM_BASE is aligned to the dmem size, so a tag compare is the range check
  // and the low address bits are directly the word index.
  assign w_sel_dmem = (i_lsu_addr >> DMEM_SHIFT) == DMEM_TAG;
  assign w_idx      = i_lsu_addr[AW+1:2];
  assign w_sel_ledr = i_lsu_addr[31:4] == 28'h000_0700;
  assign w_sel_ledg = i_lsu_addr[31:4] == 28'h000_0701;
  assign w_sel_hex  = i_lsu_addr[31:3] == 29'h0000_0E04;
  assign w_sel_lcd  = i_lsu_addr[31:4] == 28'h000_0703;
  assign w_sel_sw   = i_lsu_addr[31:4] == 28'h000_0780;
  assign w_sel_btn  = i_lsu_addr[31:4] == 28'h000_0781;

  // Byte-lane enables and store data replicated onto every lane it may occupy
  always_comb begin
    w_be    = 4'b0000;
    w_wdata = i_st_data;
    if (w_is_byte) begin
      w_be[w_off] = 1'b1;
      w_wdata     = {4{i_st_data[7:0]}};
    end else if (w_is_half) begin
      w_be    = w_off[1] ? 4'b1100 : 4'b0011;
      w_wdata = {2{i_st_data[15:0]}};
    end else if (w_is_word) begin
      w_be = 4'b1111;
    end
  end

  function automatic logic [31:0] f_merge(input logic [31:0] old_val,
                                          input logic [31:0] new_val,
                                          input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

  // Data memory write port; contents are deliberately not reset
  always_ff @(posedge i_clk) begin
    if (w_st && w_sel_dmem) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_dmem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
      end
    end
  end

  // Writable peripheral registers with lane-granular updates
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ledr <= '0;
      r_ledg <= '0;
      r_lcd  <= '0;
      for (int k = 0; k < 8; k++) r_hex[k] <= '0;
    end else if (w_st) begin
      if (w_sel_ledr) r_ledr <= f_merge(r_ledr, w_wdata, w_be);
      if (w_sel_ledg) r_ledg <= f_merge(r_ledg, w_wdata, w_be);
      if (w_sel_lcd)  r_lcd  <= f_merge(r_lcd, w_wdata, w_be);
      for (int k = 0; k < 8; k++) begin
        if (k < NUM_HEX && w_sel_hex && (i_lsu_addr[2] == k[2]) && w_be[k[1:0]])
          r_hex[k] <= w_wdata[8*(k%4) +: 7];
      end
    end
  end

  // Two-flop synchronisers for the asynchronous board inputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sw_s1  <= '0;
      r_sw_s2  <= '0;
      r_btn_s1 <= '0;
      r_btn_s2 <= '0;
    end else begin
      r_sw_s1  <= i_io_sw;
      r_sw_s2  <= r_sw_s1;
      r_btn_s1 <= i_io_btn;
      r_btn_s2 <= r_btn_s1;
    end
  end

  // Pack the four digits of the addressed hex word, one per byte lane
  always_comb begin
    w_hex_word = '0;
    for (int n = 0; n < 4; n++) begin
      w_hex_word[8*n +: 7] = r_hex[{i_lsu_addr[2], 2'(n)}];
    end
  end

  // Word read mux across all regions; unmapped space reads zero
  always_comb begin
    w_rd_word = '0;
    if (w_sel_dmem)      w_rd_word = r_dmem[w_idx];
    else if (w_sel_ledr) w_rd_word = r_ledr;
    else if (w_sel_ledg) w_rd_word = r_ledg;
    else if (w_sel_hex)  w_rd_word = w_hex_word;
    else if (w_sel_lcd)  w_rd_word = r_lcd;
    else if (w_sel_sw)   w_rd_word = r_sw_s2;
    else if (w_sel_btn)  w_rd_word = {28'h000_0000, r_btn_s2};
  end

  assign w_lane = w_rd_word >> {w_off, 3'b000};

  // Right-justify the addressed lanes and extend to 32 bits
  always_comb begin
    w_ext = w_lane;
    if (w_is_byte) begin
      w_ext = w_is_unsigned ? {24'h00_0000, w_lane[7:0]}
                            : {{24{w_lane[7]}}, w_lane[7:0]};
    end else if (w_is_half) begin
      w_ext = w_is_unsigned ? {16'h0000, w_lane[15:0]}
                            : {{16{w_lane[15]}}, w_lane[15:0]};
    end
  end

  // Registered load response and error pulse; erroneous loads still answer with zero
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ld_data  <= '0;
      r_ld_valid <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_ld_valid <= i_lsu_req & ~i_lsu_wren;
      r_err      <= i_lsu_req & w_err;
      r_ld_data  <= w_ld ? w_ext : '0;
    end
  end

  assign o_ld_data  = r_ld_data;
  assign o_ld_valid = r_ld_valid;
  assign o_err      = r_err;
  assign o_io_ledr  = r_ledr;
  assign o_io_ledg  = r_ledg;
  assign o_io_lcd   = r_lcd;

  for (genvar k = 0; k < NUM_HEX; k++) begin : g_hex_out
    assign o_io_hex[7*k +: 7] = r_hex[k];
  end

endmodule

// File: tb/tb_lsu_bytelane.sv
// Bench for lsu_bytelane: a byte-level reference model produces the expected
// response of every request, which is queued when the request is driven and
// popped against the DUT once the response is due.
module tb_lsu_bytelane;

  localparam int          DMEM_WORDS = 2048;
  localparam logic [31:0] BASE       = 32'h0000_2000;
  localparam int          NUM_HEX    = 8;
  localparam logic [2:0]  LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;

  logic                 clk = 1'b0;
  logic                 i_rst;
  logic                 i_lsu_req;
  logic                 i_lsu_wren;
  logic [31:0]          i_lsu_addr;
  logic [2:0]           i_lsu_size;
  logic [31:0]          i_st_data;
  logic [31:0]          i_io_sw;
  logic [3:0]           i_io_btn;
  logic [31:0]          o_ld_data;
  logic                 o_ld_valid;
  logic                 o_err;
  logic [31:0]          o_io_ledr;
  logic [31:0]          o_io_ledg;
  logic [7*NUM_HEX-1:0] o_io_hex;
  logic [31:0]          o_io_lcd;

  always #5 clk = ~clk;

  lsu_bytelane #(.DMEM_WORDS(DMEM_WORDS), .DMEM_BASE(BASE), .NUM_HEX(NUM_HEX)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_lsu_req(i_lsu_req), .i_lsu_wren(i_lsu_wren),
    .i_lsu_addr(i_lsu_addr), .i_lsu_size(i_lsu_size), .i_st_data(i_st_data),
    .i_io_sw(i_io_sw), .i_io_btn(i_io_btn), .o_ld_data(o_ld_data),
    .o_ld_valid(o_ld_valid), .o_err(o_err), .o_io_ledr(o_io_ledr),
    .o_io_ledg(o_io_ledg), .o_io_hex(o_io_hex), .o_io_lcd(o_io_lcd)
  );

  typedef struct {
    bit          v;
    bit          e;
    bit          cd;
    logic [31:0] d;
  } exp_t;

  exp_t        sb_q[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] last_ld = '0;

  // Reference model state
  bit   [7:0]  mem_m [int unsigned];
  logic [31:0] ledr_m, ledg_m, lcd_m;
  logic [6:0]  hex_m [8];
  logic [31:0] sw_d1, sw_d2;
  logic [3:0]  btn_d1, btn_d2;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic bit in_dmem(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'(4 * DMEM_WORDS));
  endfunction

  function automatic logic [7:0] rd_byte(input logic [31:0] a);
    logic [7:0] r;
    r = 8'h00;
    if (in_dmem(a)) begin
      if (mem_m.exists(a)) r = mem_m[a];
    end else if (a[31:4] == 28'h000_0700) r = ledr_m[8*a[1:0] +: 8];
    else if (a[31:4] == 28'h000_0701) r = ledg_m[8*a[1:0] +: 8];
    else if (a[31:4] == 28'h000_0703) r = lcd_m[8*a[1:0] +: 8];
    else if (a[31:3] == 29'h0000_0E04) r = {1'b0, hex_m[a[2:0]]};
    else if (a[31:4] == 28'h000_0780) r = sw_d2[8*a[1:0] +: 8];
    else if (a[31:4] == 28'h000_0781) r = (a[1:0] == 2'b00) ? {4'h0, btn_d2} : 8'h00;
    return r;
  endfunction

  task automatic wr_byte(input logic [31:0] a, input logic [7:0] d);
    if (in_dmem(a)) mem_m[a] = d;
    else if (a[31:4] == 28'h000_0700) ledr_m[8*a[1:0] +: 8] = d;
    else if (a[31:4] == 28'h000_0701) ledg_m[8*a[1:0] +: 8] = d;
    else if (a[31:4] == 28'h000_0703) lcd_m[8*a[1:0] +: 8] = d;
    else if (a[31:3] == 29'h0000_0E04) begin
      if (int'(a[2:0]) < NUM_HEX) hex_m[a[2:0]] = d[6:0];
    end
  endtask

  // One bus cycle: predict, queue, drive, clock, then pop and compare
  task automatic access(input bit req, input bit wr, input logic [31:0] a,
                        input logic [2:0] sz, input logic [31:0] d, input bit rst = 1'b0);
    exp_t e;
    exp_t got;
    int n;
    bit sgn, bad;
    logic [31:0] v;
    logic [7*NUM_HEX-1:0] hx;
    e = '{v: 1'b0, e: 1'b0, cd: 1'b0, d: 32'h0};
    n = 4; sgn = 1'b0; bad = 1'b0;
    case (sz)
      LB:  begin n = 1; sgn = 1'b1; end
      LH:  begin n = 2; sgn = 1'b1; end
      LW:  n = 4;
      LBU: n = 1;
      LHU: n = 2;
      default: bad = 1'b1;
    endcase
    if (n == 2 && a[0]) bad = 1'b1;
    if (n == 4 && a[1:0] != 2'b00) bad = 1'b1;
    if (rst) begin
      e.cd = 1'b1;
    end else if (req) begin
      e.e = bad;
      if (!wr) begin
        e.v = 1'b1; e.cd = 1'b1; v = '0;
        if (!bad) begin
          for (int i = 0; i < n; i++) v[8*i +: 8] = rd_byte(a + 32'(i));
          if (sgn && n == 1) v = {{24{v[7]}}, v[7:0]};
          if (sgn && n == 2) v = {{16{v[15]}}, v[15:0]};
        end
        e.d = v;
      end
    end
    sb_q.push_back(e);
    i_rst = rst; i_lsu_req = req; i_lsu_wren = wr;
    i_lsu_addr = a; i_lsu_size = sz; i_st_data = d;
    @(posedge clk);
    if (rst) begin
      ledr_m = '0; ledg_m = '0; lcd_m = '0;
      for (int k = 0; k < 8; k++) hex_m[k] = '0;
      sw_d1 = '0; sw_d2 = '0; btn_d1 = '0; btn_d2 = '0;
    end else begin
      if (req && wr && !bad) begin
        for (int i = 0; i < n; i++) wr_byte(a + 32'(i), d[8*i +: 8]);
      end
      sw_d2 = sw_d1; sw_d1 = i_io_sw;
      btn_d2 = btn_d1; btn_d1 = i_io_btn;
    end
    #1;
    got = sb_q.pop_front();
    chk("ld_valid", 64'(o_ld_valid), 64'(got.v));
    chk("err", 64'(o_err), 64'(got.e));
    if (got.cd) chk("ld_data", 64'(o_ld_data), 64'(got.d));
    if (o_ld_valid) last_ld = o_ld_data;
    hx = '0;
    for (int k = 0; k < NUM_HEX; k++) hx[7*k +: 7] = hex_m[k];
    chk("ledr", 64'(o_io_ledr), 64'(ledr_m));
    chk("ledg", 64'(o_io_ledg), 64'(ledg_m));
    chk("lcd", 64'(o_io_lcd), 64'(lcd_m));
    chk("hex", 64'(o_io_hex), 64'(hx));
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) access(1'b0, 1'b0, 32'h0, LW, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra;
    logic [2:0]  rs;
    logic [2:0]  sizes [10];
    sizes = '{LB, LH, LW, LBU, LHU, LW, LB, 3'b011, 3'b110, 3'b111};
    i_rst = 1'b1; i_lsu_req = 1'b0; i_lsu_wren = 1'b0; i_lsu_addr = '0;
    i_lsu_size = '0; i_st_data = '0; i_io_sw = '0; i_io_btn = '0;
    ledr_m = '0; ledg_m = '0; lcd_m = '0;
    for (int k = 0; k < 8; k++) hex_m[k] = '0;
    sw_d1 = '0; sw_d2 = '0; btn_d1 = '0; btn_d2 = '0;

    access(1'b0, 1'b0, 32'h0, LW, 32'h0, 1'b1);
    access(1'b0, 1'b0, 32'h0, LW, 32'h0, 1'b1);
    chk("rst_valid", 64'(o_ld_valid), 64'h0);
    idle(1);

    // Sized loads with sign and zero extension
    access(1'b1, 1'b1, BASE + 8, LW, 32'hDEAD_BEEF);
    access(1'b1, 1'b0, BASE + 11, LB, 32'h0);
    chk("t1_lb", 64'(last_ld), 64'hFFFF_FFDE);
    access(1'b1, 1'b0, BASE + 11, LBU, 32'h0);
    chk("t1_lbu", 64'(last_ld), 64'h0000_00DE);
    access(1'b1, 1'b0, BASE + 10, LH, 32'h0);
    chk("t1_lh", 64'(last_ld), 64'hFFFF_DEAD);
    access(1'b1, 1'b0, BASE + 8, LHU, 32'h0);
    chk("t1_lhu", 64'(last_ld), 64'h0000_BEEF);

    // Lane-merged stores
    access(1'b1, 1'b1, BASE + 0, LW, 32'h1122_3344);
    access(1'b1, 1'b1, BASE + 1, LB, 32'hFFFF_FFAA);
    access(1'b1, 1'b1, BASE + 2, LH, 32'hFFFF_5566);
    access(1'b1, 1'b0, BASE + 0, LW, 32'h0);
    chk("t2_lw", 64'(last_ld), 64'h5566_AA44);

    // Misalignment and illegal size
    access(1'b1, 1'b0, BASE + 2, LW, 32'h0);
    chk("t3_lw_mis_err", 64'(o_err), 64'h1);
    chk("t3_lw_mis_data", 64'(last_ld), 64'h0);
    access(1'b1, 1'b1, BASE + 1, LH, 32'h0000_7777);
    access(1'b1, 1'b1, BASE + 0, 3'b011, 32'hFFFF_FFFF);
    access(1'b1, 1'b0, BASE + 4, 3'b110, 32'h0);
    access(1'b1, 1'b0, BASE + 0, LW, 32'h0);
    chk("t3_mem_kept", 64'(last_ld), 64'h5566_AA44);

    // Hex digits and other peripherals
    access(1'b1, 1'b1, 32'h7024, LW, 32'h0F0E_0D0C);
    chk("t4_hex_hi", 64'(o_io_hex[55:28]), 64'({7'h0F, 7'h0E, 7'h0D, 7'h0C}));
    access(1'b1, 1'b1, 32'h7021, LB, 32'h0000_007F);
    chk("t4_hex_lo", 64'(o_io_hex[27:0]), 64'({7'h00, 7'h00, 7'h7F, 7'h00}));
    access(1'b1, 1'b0, 32'h7024, LW, 32'h0);
    chk("t4_hex_rd", 64'(last_ld), 64'h0F0E_0D0C);
    access(1'b1, 1'b1, 32'h7022, LH, 32'h0000_BEEF);
    access(1'b1, 1'b1, 32'h7013, LB, 32'h0000_00C3);
    access(1'b1, 1'b1, 32'h703C, LW, 32'h1234_ABCD);
    access(1'b1, 1'b0, 32'h7006, LHU, 32'h0);
    access(1'b1, 1'b0, 32'h7020, LH, 32'h0);
    access(1'b1, 1'b1, 32'h7800, LW, 32'hFFFF_FFFF);

    // Synchronised switches and buttons
    i_io_sw = 32'h1234_5678; i_io_btn = 4'b1010;
    idle(2);
    access(1'b1, 1'b0, 32'h7800, LW, 32'h0);
    chk("t5_sw", 64'(last_ld), 64'h1234_5678);
    access(1'b1, 1'b0, 32'h7810, LW, 32'h0);
    chk("t5_btn", 64'(last_ld), 64'h0000_000A);
    i_io_sw = 32'hA5A5_0F0F;
    access(1'b1, 1'b0, 32'h7800, LW, 32'h0);
    chk("t5_sw_old", 64'(last_ld), 64'h1234_5678);
    access(1'b1, 1'b0, 32'h7800, LW, 32'h0);
    access(1'b1, 1'b0, 32'h7800, LW, 32'h0);
    chk("t5_sw_new", 64'(last_ld), 64'hA5A5_0F0F);

    // Reset beats a same-cycle load; dmem survives reset
    access(1'b1, 1'b0, BASE + 0, LW, 32'h0, 1'b1);
    chk("t6_no_valid", 64'(o_ld_valid), 64'h0);
    chk("t6_ledr_zero", 64'(o_io_ledr), 64'h0);
    access(1'b1, 1'b1, 32'h9000, LW, 32'hCAFE_F00D);
    access(1'b1, 1'b0, 32'h9000, LW, 32'h0);
    chk("t6_unmapped", 64'(last_ld), 64'h0);
    access(1'b1, 1'b0, BASE + 0, LW, 32'h0);
    chk("t6_mem_kept", 64'(last_ld), 64'h5566_AA44);

    // Randomised mix over dmem, peripherals and unmapped space
    for (int w = 0; w < 8; w++) access(1'b1, 1'b1, BASE + 32'(4 * w), LW, $urandom);
    for (int it = 0; it < 300; it++) begin
      case ($urandom_range(0, 4))
        0, 1: ra = BASE + 32'($urandom_range(0, 31));
        2:    ra = 32'h7000 + 32'($urandom_range(0, 63));
        3:    ra = 32'h7800 + 32'($urandom_range(0, 31));
        default: ra = 32'h9000 + 32'($urandom_range(0, 255));
      endcase
      rs = sizes[$urandom_range(0, 9)];
      if ($urandom_range(0, 15) == 0) i_io_sw = $urandom;
      if ($urandom_range(0, 15) == 0) i_io_btn = 4'($urandom);
      access(1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1)), ra, rs, $urandom);
    end
    idle(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
